// File: rtl/button_debounce.sv
// Per-channel button debouncer: two-flop synchronizer followed by a four-state
// qualification FSM that accepts a level only after DEB_CYCLES stable samples.
module button_debounce #(
  parameter int N_BTN      = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_out,
  output logic [N_BTN-1:0] busy
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Bit 1 is the debounced level, bit 0 the qualification flag, so both
  // outputs come straight off the state flops.
  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } state_t;

  logic [N_BTN-1:0] s1_r;
  logic [N_BTN-1:0] s2_r;

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= {N_BTN{1'b0}};
      s2_r <= {N_BTN{1'b0}};
    end else begin
      s1_r <= btn_in;
      s2_r <= s1_r;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;

    // State and counter register for this channel.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= S_LOW;
        cnt_r   <= CNT_ZERO;
      end else begin
        state_r <= state_s;
        cnt_r   <= cnt_s;
      end
    end

    // Next-state logic: a reversal of s2 mid-qualification drops back to the
    // previous stable level; the counter saturates at CNT_LAST by leaving it.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
        S_LOW: begin
          if (s2_r[g]) begin
            state_s = S_RISE;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = S_LOW;
          end
        end
        S_RISE: begin
          if (!s2_r[g]) begin
            state_s = S_LOW;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = S_HIGH;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        S_HIGH: begin
          if (!s2_r[g]) begin
            state_s = S_FALL;
            cnt_s   = CNT_ZERO;
          end else begin
            state_s = S_HIGH;
          end
        end
        S_FALL: begin
          if (s2_r[g]) begin
            state_s = S_HIGH;
            cnt_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_s = S_LOW;
            cnt_s   = CNT_ZERO;
          end else begin
            cnt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_s = S_LOW;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end

    assign btn_out[g] = state_r[1];
    assign busy[g]    = state_r[0];
  end

endmodule

// File: tb/tb_button_debounce.sv
// Randomized and directed bench for button_debounce, checked every cycle
// against a run-length reference model of the debounce rules.
module tb_button_debounce;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] btn_out;
  logic [N-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: delayed input samples, accepted level, and how many
  // consecutive edges the synchronized level has disagreed with it.
  logic [N-1:0] m_s1, m_s2, m_out;
  int           m_run [N];

  always #5 clk = ~clk;

  button_debounce #(.N_BTN(N), .DEB_CYCLES(D)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_out (btn_out),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] m_busy();
    logic [N-1:0] b;
    for (int c = 0; c < N; c++) b[c] = (m_run[c] != 0);
    return b;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_out = '0;
      for (int c = 0; c < N; c++) m_run[c] = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        if (m_s2[c] != m_out[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_out[c] = ~m_out[c];
            m_run[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_out", btn_out, m_out);
    check("busy", busy, m_busy());
  endtask

  // Edges after the capture edge until channel ch reaches level lvl.
  task automatic wait_out(input int ch, input logic lvl, output int k);
    k = 0;
    while (btn_out[ch] !== lvl && k < 40) begin
      tick();
      k++;
    end
  endtask

  int  k;
  int  hold [N];
  bit  saw_busy;
  bit  saw_out;

  initial begin
    rst    = 1'b1;
    btn_in = '0;
    m_s1 = '0; m_s2 = '0; m_out = '0;
    for (int c = 0; c < N; c++) m_run[c] = 0;
    tick(); tick();
    check("rst_out", btn_out, 4'h0);
    check("rst_busy", busy, 4'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Clean press on channel 0.
    btn_in[0] = 1'b1;
    tick();
    tick();
    check("press_busy_early", busy[0], 1'b0);
    tick();
    check("press_busy", busy[0], 1'b1);
    wait_out(0, 1'b1, k);
    check("press_lat", k + 2, 6);
    check("press_others", btn_out[3:1], 3'b000);

    // Three-cycle glitch on channel 1 must never be accepted.
    saw_busy = 1'b0; saw_out = 1'b0;
    btn_in[1] = 1'b1;
    repeat (3) begin tick(); saw_busy |= busy[1]; saw_out |= btn_out[1]; end
    btn_in[1] = 1'b0;
    repeat (8) begin tick(); saw_busy |= busy[1]; saw_out |= btn_out[1]; end
    check("glitch_busy_seen", saw_busy, 1'b1);
    check("glitch_out", saw_out, 1'b0);
    check("glitch_busy_end", busy[1], 1'b0);

    // Bounce on channel 2, then settle high.
    for (int i = 0; i < 10; i++) begin
      btn_in[2] = ~btn_in[2];
      tick(); tick();
      check("bounce_out", btn_out[2], 1'b0);
    end
    btn_in[2] = 1'b1;
    tick();
    wait_out(2, 1'b1, k);
    check("bounce_lat", k, 6);

    // Release on channel 0 with a one-cycle return high that restarts the count.
    btn_in[0] = 1'b0;
    tick(); tick(); tick();
    btn_in[0] = 1'b1;
    tick();
    btn_in[0] = 1'b0;
    tick();
    wait_out(0, 1'b0, k);
    check("release_lat", k, 6);

    // Reset while channel 3 is mid-qualification.
    btn_in[3] = 1'b1;
    repeat (4) tick();
    check("mid_rise_busy", busy[3], 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_out", btn_out[3], 1'b0);
    check("rst_mid_busy", busy[3], 1'b0);
    rst = 1'b0;
    tick();
    wait_out(3, 1'b1, k);
    check("post_rst_lat", k, 6);

    // All channels rising together.
    btn_in = 4'h0;
    repeat (12) tick();
    check("all_low", btn_out, 4'h0);
    btn_in = 4'hf;
    tick();
    wait_out(0, 1'b1, k);
    check("all_lat", k, 6);
    check("all_same_edge", btn_out, 4'hf);

    // Randomized bouncing on every channel with occasional resets.
    for (int c = 0; c < N; c++) hold[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          hold[c]   = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
        end else begin
          hold[c]--;
        end
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter: N_BTN, 4, number of independent button channels (1..8).
REQ-002 Parameter: DEB_CYCLES, 16, consecutive stable synchronized samples required to accept a level change (2..65535).
REQ-003 Port: clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: btn_in  input  N_BTN  raw, asynchronous, bouncing button levels.
REQ-006 Port: btn_out  output  N_BTN  debounced level per channel, registered; feeds the downstream edge detector.
REQ-007 Port: busy  output  N_BTN  per-channel flag, high while a level change is being qualified, registered.

Function
REQ-008 Each btn_in bit SHALL pass through a two-flop synchronizer (s1, s2) before use; no logic SHALL sample btn_in directly.
REQ-009 Each channel SHALL own an independent FSM and a counter of width clog2(DEB_CYCLES); channels SHALL NOT share state.
REQ-010 FSM states: S_LOW (btn_out=0, busy=0), S_RISE (btn_out=0, busy=1), S_HIGH (btn_out=1, busy=0), S_FALL (btn_out=1, busy=1).
REQ-011 S_LOW: s2=1 -> S_RISE with cnt=0; s2=0 -> remain.
REQ-012 S_RISE: s2=0 -> S_LOW with cnt=0; s2=1 and cnt<DEB_CYCLES-1 -> cnt+1; s2=1 and cnt=DEB_CYCLES-1 -> S_HIGH with cnt=0.
REQ-013 S_HIGH: s2=0 -> S_FALL with cnt=0; s2=1 -> remain.
REQ-014 S_FALL: s2=1 -> S_HIGH with cnt=0; s2=0 and cnt<DEB_CYCLES-1 -> cnt+1; s2=0 and cnt=DEB_CYCLES-1 -> S_LOW with cnt=0.
REQ-015 Latency: for a clean change first captured into s1 at edge t, btn_out SHALL change at edge t+DEB_CYCLES+2, never earlier.
REQ-016 Any single-sample reversal of s2 during S_RISE/S_FALL SHALL abandon qualification and restart counting from zero on the next change.
REQ-017 The counter SHALL never exceed DEB_CYCLES-1 and SHALL never wrap.
REQ-018 btn_out and busy SHALL be driven directly from registered state, glitch-free, changing only on clk rising edges.
REQ-019 Simultaneous changes on several channels SHALL each follow REQ-011..REQ-015 independently and may update btn_out in the same cycle.
REQ-020 btn_out SHALL change by at most one transition per DEB_CYCLES+1 cycles per channel.

Reset
REQ-021 While rst=1 at a rising edge: s1, s2, cnt = 0; FSM = S_LOW; btn_out = 0; busy = 0 on all channels.
REQ-022 rst SHALL take priority over all FSM transitions, including mid-qualification in S_RISE/S_FALL.
REQ-023 After rst deasserts with a button already held, full qualification per REQ-015 SHALL be required before btn_out rises; no state carries across reset.

Verification (N_BTN=4, DEB_CYCLES=4)
REQ-024 Reset, then btn_in[0]=1 captured at edge 10 and held -> busy[0]=1 from edge 12, btn_out[0]=1 and busy[0]=0 at edge 16; other bits stay 0.
REQ-025 btn_in[1]=1 for 3 cycles, then 0 -> btn_out[1] stays 0 throughout, busy[1] pulses high and returns to 0, no other channel affected.
REQ-026 Bounce: btn_in[2] toggles every 2 cycles for 20 cycles, then stays 1 (last change captured at edge T) -> btn_out[2] stays 0 until it rises exactly at edge T+6.
REQ-027 From btn_out[0]=1, drop btn_in[0] to 0 captured at edge T -> btn_out[0] falls at edge T+6; a 1-cycle return to 1 before then restarts the count.
REQ-028 rst pulsed while channel 3 is in S_RISE with btn_in[3] still high -> btn_out[3]=0 and busy[3]=0 at the reset edge; after release btn_out[3] rises 6 edges after the first post-reset s1 capture.
REQ-029 All four btn_in bits rise together -> all btn_out bits rise on the same edge, 6 edges after capture.
